fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the controller. Owns the PC.
//  Requests one instruction word from memory and latches it in an instruction register.
//  Splits the word into the op_code/ext_op_code/register/immediate fields that the controller and datapath consume.
//  Holds the instruction until the datapath signals completion, then updates the PC from the controller's pc_src.
// PARAMETERS
//  WIDTH     16      data/address/instruction word width
//  OP_BITS   4       width of op_code, ext_op_code, rdest, rsrc fields
//  RESET_PC  16'h0   PC value loaded on reset
// PORTS
//  clk           in   1        single clock, all state on rising edge
//  reset         in   1        asynchronous, active-high; clears all state
//  mem_rdata     in   WIDTH    instruction word from memory
//  mem_ready     in   1        mem_rdata valid this cycle (only honoured while mem_req=1)
//  mem_req       out  1        fetch request, held until mem_ready
//  mem_addr      out  WIDTH    fetch address (= pc_out)
//  pc_src        in   2        from controller: 00/10 PC+1, 01 jump_target, 11 PC+disp if branch_taken
//  jump_target   in   WIDTH    register value for JAL/JCOND
//  branch_taken  in   1        Bcond result; qualifies pc_src=11
//  exec_done     in   1        datapath finished current instruction
//  instr_valid   out  1        fields below hold a valid instruction
//  op_code       out  OP_BITS  IR[15:12]
//  rdest         out  OP_BITS  IR[11:8]
//  ext_op_code   out  OP_BITS  IR[7:4]
//  rsrc          out  OP_BITS  IR[3:0]
//  imm           out  8        IR[7:0] (raw; sign/zero extension done downstream)
//  pc_out        out  WIDTH    address of current instruction
//  pc_plus1      out  WIDTH    pc_out+1 mod 2^WIDTH (JAL link value)
// BEHAVIOUR
//  Reset values
//   - PC=RESET_PC, IR=0, state=RESET_WAIT.
//   - Outputs: mem_req=0, instr_valid=0, all fields 0, pc_plus1=RESET_PC+1.
//  FSM: RESET_WAIT -> FETCH -> EXEC -> FETCH ...
//   - RESET_WAIT: one cycle after reset deasserts, mem_req=0; always goes to FETCH.
//   - FETCH: mem_req=1, mem_addr=PC.
//     - Edge with mem_ready=1: IR<=mem_rdata, go to EXEC.
//     - Otherwise stay in FETCH; no timeout.
//     - mem_ready in the same cycle mem_req first rises is accepted (zero-wait memory).
//   - EXEC: instr_valid=1, mem_req=0, IR and fields stable.
//     - Edge with exec_done=1: PC<=next_pc, go to FETCH.
//     - instr_valid drops in the following cycle.
//  Latency
//   - Minimum of 2 cycles per instruction: 1 FETCH + 1 EXEC.
//   - Fields are visible the cycle after the accepting mem_ready edge.
//  next_pc, all arithmetic mod 2^WIDTH
//   - pc_src 00 or 10: PC+1.
//   - pc_src 01: jump_target.
//   - pc_src 11: PC + sext(imm) when branch_taken=1, else PC+1.
//   - PC=16'hFFFF with +1 wraps to 16'h0000.
//   - disp 8'h80 = -128.
//  Boundary conditions
//   - mem_ready outside FETCH: ignored, IR unchanged.
//   - exec_done outside EXEC: ignored.
//   - exec_done and mem_ready in the same cycle: only the one relevant to the current state acts.
//   - pc_src/jump_target/branch_taken are sampled only on the exec_done edge.
//   - Reset asserted mid-FETCH or mid-EXEC:
//     - Immediate async clear; a pending memory word is discarded.
//     - mem_req drops combinationally-free, i.e. directly from a reset register.
// TESTING
//  1. Reset then zero-wait memory returning 16'h0512 at addr 0:
//     -> mem_req=1 addr=0; next cycle instr_valid=1, op=0 rdest=5 ext=1 rsrc=2.
//  2. mem_ready held low 3 cycles in FETCH:
//     -> mem_req stays 1, addr stable, instr_valid=0; captures on the 4th cycle.
//  3. PC=16'h0010, pc_src=01, jump_target=16'h1234, exec_done:
//     -> next mem_addr=16'h1234; pc_plus1 was 16'h0011.
//  4. PC=16'h0020, pc_src=11, imm=8'hFE:
//     -> branch_taken=1 gives next addr 16'h001E; branch_taken=0 gives 16'h0021.
//  5. PC=16'hFFFF, pc_src=10, exec_done -> next mem_addr=16'h0000.
//  6. Reset asserted mid-FETCH with mem_ready high:
//     -> outputs clear immediately, IR=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word into the IR and holds it until exec_done.
// Minimum 2 cycles per instruction (FETCH + EXEC); memory stalls hold FETCH indefinitely.
module fetch_unit #(
  parameter int              WIDTH    = 16,
  parameter int              OP_BITS  = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic [WIDTH-1:0]   mem_addr,
  input  logic [1:0]         pc_src,
  input  logic [WIDTH-1:0]   jump_target,
  input  logic               branch_taken,
  input  logic               exec_done,
  output logic               instr_valid,
  output logic [OP_BITS-1:0] op_code,
  output logic [OP_BITS-1:0] rdest,
  output logic [OP_BITS-1:0] ext_op_code,
  output logic [OP_BITS-1:0] rsrc,
  output logic [7:0]         imm,
  output logic [WIDTH-1:0]   pc_out,
  output logic [WIDTH-1:0]   pc_plus1
);

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] disp;
  logic [WIDTH-1:0] next_pc;

  assign disp     = {{(WIDTH-8){ir[7]}}, ir[7:0]};
  assign pc_plus1 = pc + {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    next_pc = pc_plus1;
    case (pc_src)
      2'b01:   next_pc = jump_target;
      2'b11:   if (branch_taken) next_pc = pc + disp;
      default: next_pc = pc_plus1;
    endcase
  end

  // mem_req and instr_valid are registers so reset clears them with no logic in the path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_WAIT;
      pc          <= RESET_PC;
      ir          <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          state   <= S_FETCH;
          mem_req <= 1'b1;
        end
        S_FETCH: begin
          if (mem_ready) begin
            ir          <= mem_rdata;
            state       <= S_EXEC;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            pc          <= next_pc;
            state       <= S_FETCH;
            mem_req     <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= S_WAIT;
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr    = pc;
  assign pc_out      = pc;
  assign op_code     = ir[4*OP_BITS-1 -: OP_BITS];
  assign rdest       = ir[3*OP_BITS-1 -: OP_BITS];
  assign ext_op_code = ir[2*OP_BITS-1 -: OP_BITS];
  assign rsrc        = ir[OP_BITS-1:0];
  assign imm         = ir[7:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: phase/PC model checked every negedge plus literal expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [1:0]  pc_src = 2'b00;
  logic [15:0] jump_target = '0;
  logic        branch_taken = 1'b0;
  logic        exec_done = 1'b0;
  logic        instr_valid;
  logic [3:0]  op_code, rdest, ext_op_code, rsrc;
  logic [7:0]  imm;
  logic [15:0] pc_out, pc_plus1;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.WIDTH(16), .OP_BITS(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .pc_src(pc_src), .jump_target(jump_target),
    .branch_taken(branch_taken), .exec_done(exec_done), .instr_valid(instr_valid),
    .op_code(op_code), .rdest(rdest), .ext_op_code(ext_op_code), .rsrc(rsrc),
    .imm(imm), .pc_out(pc_out), .pc_plus1(pc_plus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = post-reset idle, 1 = waiting for a word, 2 = holding an instruction
  int          m_phase = 0;
  logic [15:0] m_pc = '0;
  logic [15:0] m_ir = '0;

  function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [1:0] src,
                                             input logic [15:0] jt, input logic bt,
                                             input logic [7:0] im);
    int d;
    int r;
    d = int'(im);
    if (d > 127) d = d - 256;
    r = int'(pc) + 1;
    if (src == 2'b01) r = int'(jt);
    else if (src == 2'b11 && bt) r = int'(pc) + d;
    return r[15:0];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_pc    = 16'h0000;
      m_ir    = 16'h0000;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: if (mem_ready) begin m_ir = mem_rdata; m_phase = 2; end
        default: if (exec_done) begin
          m_pc    = model_next(m_pc, pc_src, jump_target, branch_taken, m_ir[7:0]);
          m_phase = 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if ($time > 2) begin
      logic [15:0] p1;
      p1 = m_pc + 16'h0001;
      check("m_req",   {31'b0, mem_req},     {31'b0, m_phase == 1});
      check("m_valid", {31'b0, instr_valid}, {31'b0, m_phase == 2});
      check("m_addr",  {16'b0, mem_addr},    {16'b0, m_pc});
      check("m_pc",    {16'b0, pc_out},      {16'b0, m_pc});
      check("m_pc1",   {16'b0, pc_plus1},    {16'b0, p1});
      if (m_phase == 2 || reset)
        check("m_fields", {16'b0, op_code, rdest, ext_op_code, rsrc}, {16'b0, m_ir});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in a FETCH cycle: zero-wait delivery of one word, ends in EXEC
  task automatic fetch_word(input logic [15:0] w);
    mem_rdata = w;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask

  // Called in an EXEC cycle: complete with the given control, ends in FETCH
  task automatic finish(input logic [1:0] src, input logic [15:0] jt, input logic bt);
    pc_src       = src;
    jump_target  = jt;
    branch_taken = bt;
    exec_done    = 1'b1;
    step();
    exec_done    = 1'b0;
  endtask

  task automatic goto_pc(input logic [15:0] target);
    fetch_word(16'h0000);
    finish(2'b01, target, 1'b0);
  endtask

  initial begin
    #1 reset = 1'b1;
    step();
    step();
    check("rst_req",   {31'b0, mem_req}, 32'd0);
    check("rst_pc1",   {16'b0, pc_plus1}, 32'h0001);
    mem_rdata = 16'h0512;
    mem_ready = 1'b1;
    reset = 1'b0;
    check("wait_req",  {31'b0, mem_req}, 32'd0);
    step();
    check("t1_req",    {31'b0, mem_req}, 32'd1);
    check("t1_addr",   {16'b0, mem_addr}, 32'h0000);
    step();
    check("t1_valid",  {31'b0, instr_valid}, 32'd1);
    check("t1_fields", {16'b0, op_code, rdest, ext_op_code, rsrc}, 32'h0512);
    // mem_ready with a different word during EXEC must not disturb the IR
    mem_rdata = 16'hFFFF;
    step();
    check("t1_hold",   {16'b0, op_code, rdest, ext_op_code, rsrc}, 32'h0512);
    mem_ready = 1'b0;
    finish(2'b00, 16'h0000, 1'b0);
    check("pc_inc",    {16'b0, mem_addr}, 32'h0001);
    check("valid_drop", {31'b0, instr_valid}, 32'd0);

    // Stall three cycles; exec_done asserted in FETCH must be ignored
    pc_src = 2'b01; jump_target = 16'hBEEF; exec_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2_req",  {31'b0, mem_req}, 32'd1);
      check("t2_addr", {16'b0, mem_addr}, 32'h0001);
      step();
    end
    exec_done = 1'b0;
    fetch_word(16'hA3C7);
    check("t2_fields", {16'b0, op_code, rdest, ext_op_code, rsrc}, 32'hA3C7);
    finish(2'b01, 16'h0010, 1'b0);

    fetch_word(16'h0000);
    check("t3_pc1",    {16'b0, pc_plus1}, 32'h0011);
    finish(2'b01, 16'h1234, 1'b0);
    check("t3_addr",   {16'b0, mem_addr}, 32'h1234);
    goto_pc(16'h0020);

    fetch_word(16'h00FE);
    check("t4_imm",    {24'b0, imm}, 32'h00FE);
    finish(2'b11, 16'h0000, 1'b1);
    check("t4_taken",  {16'b0, mem_addr}, 32'h001E);
    goto_pc(16'h0020);
    fetch_word(16'h00FE);
    finish(2'b11, 16'h0000, 1'b0);
    check("t4_not",    {16'b0, mem_addr}, 32'h0021);

    goto_pc(16'h0100);
    fetch_word(16'h0080);
    finish(2'b11, 16'h0000, 1'b1);
    check("disp_m128", {16'b0, mem_addr}, 32'h0080);

    goto_pc(16'hFFFF);
    fetch_word(16'h0000);
    check("t5_pc1",    {16'b0, pc_plus1}, 32'h0000);
    finish(2'b10, 16'h0000, 1'b0);
    check("t5_wrap",   {16'b0, mem_addr}, 32'h0000);

    // Reset mid-FETCH with a word being offered
    fetch_word(16'h4444);
    finish(2'b01, 16'h0777, 1'b0);
    mem_rdata = 16'hABCD;
    mem_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("t6_req",    {31'b0, mem_req}, 32'd0);
    check("t6_valid",  {31'b0, instr_valid}, 32'd0);
    check("t6_addr",   {16'b0, mem_addr}, 32'h0000);
    check("t6_ir",     {16'b0, op_code, rdest, ext_op_code, rsrc}, 32'h0000);
    step();
    reset = 1'b0;
    step();
    check("t6_restart", {16'b0, mem_addr}, 32'h0000);
    check("t6_req2",   {31'b0, mem_req}, 32'd1);
    step();
    check("t6_fields", {16'b0, op_code, rdest, ext_op_code, rsrc}, 32'hABCD);
    mem_ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
